pio_handshake_responder: RTL and testbench
==========================================

Name: pio_handshake_responder

Overview:
- Hardware-side endpoint of the software-to-hardware PIO handshake (to_hw_port[15:0], to_hw_sig[1:0] from the Nios; to_sw_sig[1:0] back to the Nios).
- Software pushes 16-bit words one at a time using a 4-phase handshake.
- The block assembles them into a WORDS-word block, presents the block to downstream logic with a valid/ready handshake, and reports ack/done/error codes back to software.

Parameters:
- WORDS, 8, words per block (block width 16*WORDS bits, 128 by default).
- SYNC_STAGES, 2, synchronizer flops on to_hw_sig (minimum 2).

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- to_hw_port  in  16  data word from software PIO.
- to_hw_sig  in  2  command from software: 00 idle, 01 write word, 10 commit block, 11 abort.
- to_sw_sig  out  2  response to software: 00 idle, 01 ack, 10 done, 11 error.
- block_data  out  16*WORDS  assembled block; word k at bits [16k+15:16k].
- block_valid  out  1  block complete and held stable.
- block_ready  in  1  downstream accepts block when high with block_valid.
- word_count  out  $clog2(WORDS+1)  words stored in current block.

Behaviour:
- Reset (async assert, sync release) values:
  - to_sw_sig = 00, block_valid = 0, block_data = 0, word_count = 0, state = IDLE.
  - Synchronizer flops and sig_q are cleared.
- Input conditioning:
  - to_hw_sig passes through SYNC_STAGES flops to give sig_s; sig_q is sig_s delayed one cycle.
  - A command is "stable" when sig_s == sig_q.
  - Commands are acted on only when stable, which rejects transient codes during 2-bit transitions.
  - to_hw_port is not synchronized. Software writes the port before raising sig, so it is sampled in the cycle the stable command is accepted.
- Latency: to_sw_sig changes on the (SYNC_STAGES+2)th rising edge after a to_hw_sig change (4 edges by default), except where COMMIT waits on block_ready.
- State IDLE (to_sw_sig = 00). On a stable nonzero command:
  - 01, word_count < WORDS: store to_hw_port at word index word_count; word_count += 1; to_sw_sig <= 01; go to WAIT_LOW.
  - 01, word_count == WORDS (overflow): no store, no count change; to_sw_sig <= 11; go to WAIT_LOW.
  - 10, word_count == WORDS: go to COMMIT.
  - 10, word_count < WORDS (short block): word_count <= 0; to_sw_sig <= 11; go to WAIT_LOW.
  - 11 (abort): word_count <= 0 (block_data not cleared); to_sw_sig <= 01; go to WAIT_LOW.
- State COMMIT:
  - block_valid = 1; block_data frozen; to_sw_sig stays 00.
  - Commands are ignored while waiting.
  - In the cycle block_valid && block_ready: block_valid <= 0, word_count <= 0, to_sw_sig <= 10; go to WAIT_LOW.
  - block_ready already high on entry: block_valid is high for exactly 1 cycle.
- State WAIT_LOW:
  - Holds to_sw_sig.
  - When stable sig_s == 00: to_sw_sig <= 00; go to IDLE.
  - No new command is accepted until software has returned to 00. The next command is therefore evaluated no earlier than the cycle after the return to IDLE.
- block_data changes only in IDLE on a word store. block_valid alone qualifies it.
- Reset mid-operation (any state): immediate return to reset values; a partially assembled block is discarded.
- WORDS = 1: a single write fills the block; word_count width 1.

Test Plan:
- Normal block: reset, block_ready = 1; write 8 words 0x1111..0x8888 with full 4-phase per word (each gets to_sw_sig = 01 then 00); commit -> block_valid for 1 cycle, block_data = 0x8888_7777_..._1111, to_sw_sig = 10, then 00 after sig = 00; word_count = 0.
- Backpressure: full block, block_ready = 0 for 20 cycles after commit -> block_valid held high, block_data stable, to_sw_sig stays 00; raise block_ready -> 1-cycle accept, to_sw_sig = 10.
- Overflow and short commit:
  - Ninth write 0xDEAD -> to_sw_sig = 11; block_data word 7 unchanged.
  - Commit after only 3 words -> to_sw_sig = 11, word_count = 0.
- Abort: write 5 words, send 11 -> to_sw_sig = 01, word_count = 0; next 8 writes plus commit produce a block with only the new words.
- Glitch/latency: drive to_hw_sig 00 -> 10 for 1 cycle -> 11 -> no action on the 10; measure 4 edges from the 11 settling to to_sw_sig = 01; hold sig = 11 for 50 cycles -> exactly one abort.
- Async reset: assert reset in COMMIT and in WAIT_LOW, off-edge -> outputs zero immediately; after release a fresh 8-word sequence works.

Source files
------------

// File: rtl/pio_handshake_responder.sv
// Hardware endpoint of the software PIO 4-phase handshake: assembles WORDS
// 16-bit words into a block, hands it downstream with valid/ready, and replies to software.
module pio_handshake_responder #(
    parameter int WORDS       = 8,
    parameter int SYNC_STAGES = 2,
    localparam int CW         = $clog2(WORDS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           to_hw_port,
    input  logic [1:0]            to_hw_sig,
    output logic [1:0]            to_sw_sig,
    output logic [16*WORDS-1:0]   block_data,
    output logic                  block_valid,
    input  logic                  block_ready,
    output logic [CW-1:0]         word_count,
    output logic [1:0]            fsm_state
);

    // Downstream handshake: a block transfers in the cycle where block_valid
    // and block_ready are both high; block_data is stable while block_valid is high.

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMMIT   = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    localparam logic [CW-1:0] FULL = CW'(WORDS);

    state_t                         state, state_n;
    logic [SYNC_STAGES-1:0][1:0]    sync_r;
    logic [1:0]                     sig_s, sig_q;
    logic                           stable;
    logic [WORDS-1:0][15:0]         words;
    logic [1:0]                     sw_n;
    logic                           valid_n;
    logic [CW-1:0]                  count_n;
    logic                           store;

    assign sig_s      = sync_r[SYNC_STAGES-1];
    assign stable     = (sig_s == sig_q);
    assign block_data = words;
    assign fsm_state  = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= '0;
            sig_q  <= 2'b00;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], to_hw_sig};
            sig_q  <= sig_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            to_sw_sig   <= 2'b00;
            block_valid <= 1'b0;
            word_count  <= '0;
            words       <= '0;
        end else begin
            state       <= state_n;
            to_sw_sig   <= sw_n;
            block_valid <= valid_n;
            word_count  <= count_n;
            for (int k = 0; k < WORDS; k++) begin
                if (store && word_count == CW'(k)) begin
                    words[k] <= to_hw_port;
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        sw_n    = to_sw_sig;
        valid_n = block_valid;
        count_n = word_count;
        store   = 1'b0;
        unique case (state)
            IDLE: begin
                if (stable && sig_s != 2'b00) begin
                    state_n = WAIT_LOW;
                    case (sig_s)
                        2'b01: begin
                            if (word_count < FULL) begin
                                store   = 1'b1;
                                count_n = word_count + CW'(1);
                                sw_n    = 2'b01;
                            end else begin
                                sw_n = 2'b11;
                            end
                        end
                        2'b10: begin
                            if (word_count == FULL) begin
                                state_n = COMMIT;
                                valid_n = 1'b1;
                            end else begin
                                count_n = '0;
                                sw_n    = 2'b11;
                            end
                        end
                        default: begin
                            // Abort drops the count only; stale words stay until overwritten.
                            count_n = '0;
                            sw_n    = 2'b01;
                        end
                    endcase
                end
            end
            COMMIT: begin
                if (block_valid && block_ready) begin
                    valid_n = 1'b0;
                    count_n = '0;
                    sw_n    = 2'b10;
                    state_n = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (stable && sig_s == 2'b00) begin
                    sw_n    = 2'b00;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pio_handshake_responder.sv
// Directed bench for pio_handshake_responder: software handshake emulation with
// hand-computed expected blocks and responses.
module tb_pio_handshake_responder;

    localparam int WORDS = 8;
    localparam int CW    = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [15:0]         to_hw_port = '0;
    logic [1:0]          to_hw_sig = 2'b00;
    logic [1:0]          to_sw_sig;
    logic [16*WORDS-1:0] block_data;
    logic                block_valid;
    logic                block_ready = 1'b1;
    logic [CW-1:0]       word_count;
    logic [1:0]          fsm_state;

    int checks   = 0;
    int failures = 0;

    pio_handshake_responder #(.WORDS(WORDS), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .to_hw_port  (to_hw_port),
        .to_hw_sig   (to_hw_sig),
        .to_sw_sig   (to_sw_sig),
        .block_data  (block_data),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .word_count  (word_count),
        .fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_resp(input logic [1:0] exp, input string tag);
        int n = 0;
        while (to_sw_sig !== exp && n < 20) begin
            step(1);
            n++;
        end
        check(tag, 128'(to_sw_sig), 128'(exp));
    endtask

    task automatic cmd(input logic [1:0] sig, input logic [15:0] data,
                       input logic [1:0] resp, input string tag);
        to_hw_port = data;
        to_hw_sig  = sig;
        wait_resp(resp, tag);
        to_hw_sig = 2'b00;
        wait_resp(2'b00, {tag, "_release"});
    endtask

    task automatic write_seq(input logic [15:0] start, input logic [15:0] incr, input int n);
        for (int i = 0; i < n; i++) begin
            cmd(2'b01, start + incr * 16'(i), 2'b01, "write_ack");
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (block_valid !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        check(tag, 128'(block_valid), 128'd1);
    endtask

    task automatic commit_accept(input logic [127:0] exp_data, input string tag);
        to_hw_sig = 2'b10;
        wait_valid({tag, "_valid"});
        check({tag, "_data"}, block_data, exp_data);
        check({tag, "_sw_during"}, 128'(to_sw_sig), 128'd0);
        step(1);
        check({tag, "_valid_drop"}, 128'(block_valid), 128'd0);
        check({tag, "_sw_done"}, 128'(to_sw_sig), 128'd2);
        check({tag, "_count"}, 128'(word_count), 128'd0);
        to_hw_sig = 2'b00;
        wait_resp(2'b00, {tag, "_release"});
    endtask

    initial begin
        logic [127:0] held;
        int n;

        // Reset values
        #1;
        check("reset_sw", 128'(to_sw_sig), 128'd0);
        check("reset_valid", 128'(block_valid), 128'd0);
        check("reset_data", block_data, 128'd0);
        check("reset_count", 128'(word_count), 128'd0);
        step(3);
        reset = 1'b0;
        step(2);

        // Normal block with ready already high
        write_seq(16'h1111, 16'h1111, 8);
        check("normal_count", 128'(word_count), 128'd8);
        commit_accept(128'h8888_7777_6666_5555_4444_3333_2222_1111, "normal");

        // Backpressure
        write_seq(16'h2000, 16'h0011, 8);
        block_ready = 1'b0;
        to_hw_sig   = 2'b10;
        wait_valid("bp_valid");
        held = block_data;
        check("bp_data", held, 128'h2077_2066_2055_2044_2033_2022_2011_2000);
        step(20);
        check("bp_valid_held", 128'(block_valid), 128'd1);
        check("bp_data_stable", block_data, held);
        check("bp_sw_idle", 128'(to_sw_sig), 128'd0);
        block_ready = 1'b1;
        step(1);
        check("bp_valid_drop", 128'(block_valid), 128'd0);
        check("bp_sw_done", 128'(to_sw_sig), 128'd2);
        check("bp_count", 128'(word_count), 128'd0);
        to_hw_sig = 2'b00;
        wait_resp(2'b00, "bp_release");

        // Overflow on ninth write
        write_seq(16'h3000, 16'h0100, 8);
        cmd(2'b01, 16'hDEAD, 2'b11, "overflow_err");
        check("overflow_word7", 128'(block_data[127:112]), 128'h3700);
        check("overflow_count", 128'(word_count), 128'd8);
        commit_accept(128'h3700_3600_3500_3400_3300_3200_3100_3000, "overflow_commit");

        // Short commit
        write_seq(16'h4000, 16'h0001, 3);
        check("short_count_pre", 128'(word_count), 128'd3);
        cmd(2'b10, 16'h0000, 2'b11, "short_err");
        check("short_count", 128'(word_count), 128'd0);
        check("short_no_valid", 128'(block_valid), 128'd0);

        // Abort, then a fresh block
        write_seq(16'h5000, 16'h0001, 5);
        cmd(2'b11, 16'h0000, 2'b01, "abort_ack");
        check("abort_count", 128'(word_count), 128'd0);
        write_seq(16'h0A01, 16'h0001, 8);
        commit_accept(128'h0A08_0A07_0A06_0A05_0A04_0A03_0A02_0A01, "abort_block");

        // Glitch and latency: a one-cycle 10 on the way to 11 must be ignored
        write_seq(16'h6000, 16'h0001, 2);
        to_hw_sig = 2'b10;
        step(1);
        to_hw_sig = 2'b11;
        n = 0;
        while (to_sw_sig === 2'b00 && n < 12) begin
            step(1);
            n++;
        end
        check("glitch_latency", 128'(n), 128'd4);
        check("glitch_resp", 128'(to_sw_sig), 128'd1);
        check("glitch_count", 128'(word_count), 128'd0);
        step(50);
        check("hold_resp", 128'(to_sw_sig), 128'd1);
        check("hold_state", 128'(fsm_state), 128'd2);
        check("hold_count", 128'(word_count), 128'd0);
        to_hw_sig = 2'b00;
        wait_resp(2'b00, "glitch_release");

        // Async reset in COMMIT
        write_seq(16'h7000, 16'h0001, 8);
        block_ready = 1'b0;
        to_hw_sig   = 2'b10;
        wait_valid("rst_commit_valid");
        check("rst_commit_state", 128'(fsm_state), 128'd1);
        #3;
        reset = 1'b1;
        to_hw_sig = 2'b00;
        #1;
        check("rst_commit_valid0", 128'(block_valid), 128'd0);
        check("rst_commit_data0", block_data, 128'd0);
        check("rst_commit_count0", 128'(word_count), 128'd0);
        check("rst_commit_state0", 128'(fsm_state), 128'd0);
        block_ready = 1'b1;
        step(2);
        reset = 1'b0;
        step(2);

        // Async reset in WAIT_LOW
        write_seq(16'h7100, 16'h0001, 2);
        to_hw_port = 16'h7102;
        to_hw_sig  = 2'b01;
        wait_resp(2'b01, "rst_wait_ack");
        check("rst_wait_state", 128'(fsm_state), 128'd2);
        #3;
        reset = 1'b1;
        to_hw_sig = 2'b00;
        #1;
        check("rst_wait_sw0", 128'(to_sw_sig), 128'd0);
        check("rst_wait_count0", 128'(word_count), 128'd0);
        check("rst_wait_data0", block_data, 128'd0);
        step(2);
        reset = 1'b0;
        step(2);

        // Fresh sequence after reset
        write_seq(16'h1000, 16'h0101, 8);
        commit_accept(128'h1707_1606_1505_1404_1303_1202_1101_1000, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
